// File: rtl/mem_responder.sv
// Load/store responder: valid/ready request, WAIT_CYCLES wait states, held response.
// Define MEM_RESPONDER_ERR_EN to enable illegal-funct, misalignment and range errors.
module mem_responder #(
    parameter int DEPTH_LOG2  = 8,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [2:0]  req_funct,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);
    localparam int DEPTH = 1 << DEPTH_LOG2;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_e;

    function automatic logic [31:0] load_ext(input logic [31:0] word, input logic [1:0] size,
                                             input logic uns);
        logic [31:0] res;
        case (size)
            2'b00:   res = uns ? {24'd0, word[7:0]}  : {{24{word[7]}}, word[7:0]};
            2'b01:   res = uns ? {16'd0, word[15:0]} : {{16{word[15]}}, word[15:0]};
            default: res = word;
        endcase
        return res;
    endfunction

    state_e            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              write_q, write_d;
    logic [2:0]        funct_q, funct_d;
    logic [31:0]       addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              req_ready_q, req_ready_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [31:0]       rsp_rdata_q, rsp_rdata_d;
    logic              rsp_err_q, rsp_err_d;
    logic [31:0]       mem_q [DEPTH];

    logic              legal_s;
    logic              err_s;
    logic [1:0]        size_s;
    logic              uns_s;
    logic [1:0]        lane_s;
    logic [DEPTH_LOG2-1:0] idx_s;
    logic [3:0]        be_s;
    logic [31:0]       mask_s;
    logic [31:0]       wlane_s;
    logic [31:0]       wword_s;
    logic [31:0]       rdata_s;
    logic              access_s;

`ifndef MEM_RESPONDER_ERR_EN
    logic              addr_unused_s;
    assign addr_unused_s = ^addr_q[31:DEPTH_LOG2+2];
`endif

    assign idx_s    = addr_q[DEPTH_LOG2+1:2];
    assign access_s = (state_q == S_WAIT) && (cnt_q == 4'd0);

    // Decode the registered request into size, lane, byte enables and error.
    always_comb begin
        size_s = funct_q[1:0];
        uns_s  = funct_q[2];
        lane_s = addr_q[1:0];
        case (funct_q)
            3'b000, 3'b001, 3'b010: legal_s = 1'b1;
            3'b100, 3'b101:         legal_s = !write_q;
            default:                legal_s = 1'b0;
        endcase
`ifdef MEM_RESPONDER_ERR_EN
        err_s = !legal_s
              || ((size_s == 2'b01) && addr_q[0])
              || ((size_s == 2'b10) && (addr_q[1:0] != 2'b00))
              || ((addr_q >> (DEPTH_LOG2 + 2)) != 32'd0);
`else
        err_s = 1'b0;
        if (!legal_s) begin
            size_s = funct_q[1] ? 2'b10 : 2'b00;
            uns_s  = 1'b0;
        end else begin
            size_s = funct_q[1:0];
        end
        case (size_s)
            2'b00:   lane_s = addr_q[1:0];
            2'b01:   lane_s = {addr_q[1], 1'b0};
            default: lane_s = 2'b00;
        endcase
`endif
        case (size_s)
            2'b00: begin
                be_s    = 4'b0001 << lane_s;
                wlane_s = {4{wdata_q[7:0]}};
            end
            2'b01: begin
                be_s    = 4'b0011 << lane_s;
                wlane_s = {2{wdata_q[15:0]}};
            end
            default: begin
                be_s    = 4'b1111;
                wlane_s = wdata_q;
            end
        endcase
        mask_s  = {{8{be_s[3]}}, {8{be_s[2]}}, {8{be_s[1]}}, {8{be_s[0]}}};
        wword_s = (mem_q[idx_s] & ~mask_s) | (wlane_s & mask_s);
        rdata_s = load_ext(mem_q[idx_s] >> {lane_s, 3'b000}, size_s, uns_s);
    end

    // Next-state and registered-output logic for IDLE/WAIT/RESP.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        write_d     = write_q;
        funct_d     = funct_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        req_ready_d = req_ready_q;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    write_d     = req_write;
                    funct_d     = req_funct;
                    addr_d      = req_addr;
                    wdata_d     = req_wdata;
                    cnt_d       = 4'(WAIT_CYCLES);
                    req_ready_d = 1'b0;
                    state_d     = S_WAIT;
                end else begin
                    req_ready_d = 1'b1;
                end
            end
            S_WAIT: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = err_s;
                    rsp_rdata_d = (err_s || write_q) ? 32'd0 : rdata_s;
                    state_d     = S_RESP;
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    req_ready_d = 1'b1;
                    state_d     = S_IDLE;
                end else begin
                    rsp_valid_d = 1'b1;
                end
            end
            default: begin
                rsp_valid_d = 1'b0;
                req_ready_d = 1'b1;
                state_d     = S_IDLE;
            end
        endcase
    end

    // State, captured request and response registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= 4'd0;
            write_q     <= 1'b0;
            funct_q     <= 3'd0;
            addr_q      <= 32'd0;
            wdata_q     <= 32'd0;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 32'd0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            write_q     <= write_d;
            funct_q     <= funct_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    // Store commit on the access edge; the array itself is never reset.
    always_ff @(posedge clk) begin
        if (access_s && write_q && !err_s && !reset) begin
            mem_q[idx_s] <= wword_s;
        end
    end

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;
endmodule

// File: tb/tb_mem_responder.sv
// Randomized bench for mem_responder against a byte-array reference model.
module tb_mem_responder;
    localparam int DL2    = 8;
    localparam int WAITC  = 2;
    localparam int DEPTH  = 1 << DL2;
    localparam int NBYTES = 4 * DEPTH;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [2:0]  req_funct;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    int n_chk = 0;
    int n_err = 0;
    int cyc = 0;
    int last_acc = -100;
    logic [7:0] ref_mem [NBYTES];

    mem_responder #(.DEPTH_LOG2(DL2), .WAIT_CYCLES(WAITC)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_funct(req_funct), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: byte-addressed memory, access width from funct, rules applied directly.
    function automatic void ref_access(input bit w, input logic [2:0] f, input logic [31:0] a_in,
                                       input logic [31:0] wd, output bit err, output logic [31:0] rd);
        bit legal;
        bit sgn;
        int nb;
        logic [31:0] a;
        logic [31:0] v;
        legal = w ? (f <= 3'd2) : ((f <= 3'd2) || (f == 3'd4) || (f == 3'd5));
        if (legal) begin
            nb  = 1 << f[1:0];
            sgn = !f[2];
        end else begin
            nb  = f[1] ? 4 : 1;
            sgn = 1'b1;
        end
        a  = a_in;
        rd = 32'd0;
`ifdef MEM_RESPONDER_ERR_EN
        err = !legal || ((a % 32'(nb)) != 32'd0) || (a >= 32'(NBYTES));
`else
        err = 1'b0;
        a = a % 32'(NBYTES);
        a = a - (a % 32'(nb));
`endif
        if (!err) begin
            if (w) begin
                for (int i = 0; i < nb; i++) ref_mem[a + 32'(i)] = wd[8*i +: 8];
            end else begin
                v = 32'd0;
                for (int i = 0; i < nb; i++) v[8*i +: 8] = ref_mem[a + 32'(i)];
                if (sgn && (nb < 4) && v[8*nb-1]) v = v | ~((32'd1 << (8*nb)) - 32'd1);
                rd = v;
            end
        end
    endfunction

    // One full transaction, called just after a falling edge with the DUT idle.
    task automatic txn(input bit w, input logic [2:0] f, input logic [31:0] a, input logic [31:0] wd,
                       input int bp, input bit gap_chk, output logic [31:0] got);
        bit e;
        logic [31:0] r;
        logic [31:0] held;
        logic held_err;
        int n;
        ref_access(w, f, a, wd, e, r);
        chk_eq("req_ready_idle", 32'(req_ready), 32'd1);
        req_valid = 1'b1; req_write = w; req_funct = f; req_addr = a; req_wdata = wd;
        @(posedge clk);
        if (gap_chk) chk_eq("req_gap", 32'(cyc - last_acc), 32'(WAITC + 3));
        last_acc = cyc;
        @(negedge clk);
        req_valid = 1'b0;
        n = 0;
        while (!rsp_valid && n < 64) begin
            @(posedge clk);
            n++;
            @(negedge clk);
        end
        chk_eq("rsp_latency", 32'(n), 32'(WAITC + 1));
        chk_eq("rsp_err", 32'(rsp_err), 32'(e));
        chk_eq("rsp_rdata", rsp_rdata, r);
        got = rsp_rdata;
        held = rsp_rdata;
        held_err = rsp_err;
        for (int k = 0; k < bp; k++) begin
            req_valid = 1'b1; req_write = 1'b1; req_funct = 3'b010;
            req_addr = 32'h0; req_wdata = 32'hA5A5A5A5;
            @(posedge clk);
            @(negedge clk);
            chk_eq("bp_valid", 32'(rsp_valid), 32'd1);
            chk_eq("bp_rdata", rsp_rdata, held);
            chk_eq("bp_err", 32'(rsp_err), 32'(held_err));
            chk_eq("bp_req_ready", 32'(req_ready), 32'd0);
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rsp_ready = 1'b0;
        chk_eq("rsp_drop", 32'(rsp_valid), 32'd0);
        chk_eq("idle_ready", 32'(req_ready), 32'd1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] got;
        int prev_bp;
        int bp;
        reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_funct = 3'd0;
        req_addr = 32'd0; req_wdata = 32'd0; rsp_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk_eq("rst_req_ready", 32'(req_ready), 32'd1);
        chk_eq("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk_eq("rst_rsp_rdata", rsp_rdata, 32'd0);
        chk_eq("rst_rsp_err", 32'(rsp_err), 32'd0);
        reset = 1'b0;
        @(negedge clk);

        for (int i = 0; i < DEPTH; i++) txn(1'b1, 3'b010, 32'(4 * i), $urandom, 0, 1'b0, got);

        txn(1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 0, 1'b0, got);
        txn(1'b0, 3'b010, 32'h10, 32'h0, 0, 1'b1, got);
        chk_eq("plan_lw", got, 32'hDEADBEEF);
        txn(1'b1, 3'b000, 32'h11, 32'h00000055, 0, 1'b1, got);
        txn(1'b0, 3'b010, 32'h10, 32'h0, 0, 1'b1, got);
        chk_eq("plan_lw_sb", got, 32'hDEAD55EF);
        txn(1'b0, 3'b000, 32'h13, 32'h0, 0, 1'b1, got);
        chk_eq("plan_lb", got, 32'hFFFFFFDE);
        txn(1'b0, 3'b100, 32'h13, 32'h0, 0, 1'b1, got);
        chk_eq("plan_lbu", got, 32'h000000DE);
        txn(1'b0, 3'b001, 32'h12, 32'h0, 0, 1'b1, got);
        chk_eq("plan_lh", got, 32'hFFFFDEAD);
        txn(1'b0, 3'b010, 32'h12, 32'h0, 0, 1'b1, got);
`ifdef MEM_RESPONDER_ERR_EN
        chk_eq("plan_lw_mis", got, 32'h0);
`else
        chk_eq("plan_lw_mis", got, 32'hDEAD55EF);
`endif
        txn(1'b1, 3'b010, 32'h402, 32'h13579BDF, 0, 1'b1, got);
        txn(1'b0, 3'b010, 32'h400, 32'h0, 0, 1'b1, got);
        txn(1'b0, 3'b010, 32'h10, 32'h0, 5, 1'b0, got);

        txn(1'b1, 3'b010, 32'h20, 32'h0, 0, 1'b0, got);
        req_valid = 1'b1; req_write = 1'b1; req_funct = 3'b010;
        req_addr = 32'h20; req_wdata = 32'h12345678;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        reset = 1'b1;
        #1;
        chk_eq("midrst_valid", 32'(rsp_valid), 32'd0);
        chk_eq("midrst_ready", 32'(req_ready), 32'd1);
        repeat (4) begin
            @(negedge clk);
            chk_eq("midrst_hold", 32'(rsp_valid), 32'd0);
        end
        reset = 1'b0;
        txn(1'b0, 3'b010, 32'h20, 32'h0, 0, 1'b0, got);
        chk_eq("midrst_lw", got, 32'h0);

        prev_bp = 1;
        for (int t = 0; t < 400; t++) begin
            logic [31:0] a;
            a = ($urandom_range(0, 9) == 0) ? $urandom : 32'($urandom_range(0, NBYTES - 1));
            bp = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 3)) : 0;
            txn(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), a, $urandom, bp,
                (prev_bp == 0), got);
            prev_bp = bp;
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
